// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer: FSM state encoding and the
// bit-counter width helper.
package piso_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_cnt.sv
// Down-counter with load, saturating decrement and synchronous clear.
// The zero flag marks the final bit of a word.
module bit_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load beats decrement; decrement stops at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one word in through LOAD/READY, one bit
// per clock out on a flop-driven SO, with gap-free reloads in the last bit.
module piso_serializer
  import piso_defs::*;
#(
  parameter int   WIDTH     = 8,
  parameter logic INIT_VAL  = 1'b0,
  parameter bit   MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD,
  output logic             READY,
  output logic             SO,
  output logic             BUSY,
  output logic             LAST
);

  localparam int            CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             so_q, so_d;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             load_evt;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1'b1) : (w >> 1'b1);
  endfunction

  // READY depends only on registered state, never on LOAD or DIN.
  assign BUSY     = (state_q == ST_SHIFT);
  assign LAST     = BUSY && cnt_zero;
  assign READY    = (state_q == ST_IDLE) || LAST;
  assign SO       = so_q;
  assign load_evt = LOAD && READY;

  // Next-state, shift-register and serial-bit selection.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    so_d     = so_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_evt) begin
          shreg_d  = shift_word(DIN);
          so_d     = head_bit(DIN);
          cnt_load = 1'b1;
          state_d  = ST_SHIFT;
        end else begin
          so_d = INIT_VAL;
        end
      end
      ST_SHIFT: begin
        if (!cnt_zero) begin
          so_d    = head_bit(shreg_q);
          shreg_d = shift_word(shreg_q);
          cnt_dec = 1'b1;
        end else if (load_evt) begin
          shreg_d  = shift_word(DIN);
          so_d     = head_bit(DIN);
          cnt_load = 1'b1;
        end else begin
          so_d    = INIT_VAL;
          state_d = ST_IDLE;
        end
      end
      default: begin
        so_d    = INIT_VAL;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, shift register and SO flop; CLR discards any in-flight word.
  always_ff @(posedge C) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      so_q    <= INIT_VAL;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      so_q    <= so_d;
    end
  end

  bit_cnt #(
    .W(CW)
  ) u_bit_cnt (
    .clk      (C),
    .clr      (CLR),
    .load     (cnt_load),
    .load_val (CNT_MAX),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: two serializers (MSB-first/idle 0 and LSB-first/idle 1)
// share stimulus; accepted words push their expected bit streams into a queue.
module tb_piso_serializer;

  localparam int W = 8;

  logic         c = 1'b0;
  logic         clr;
  logic         load;
  logic [W-1:0] din;
  logic         ready_a, so_a, busy_a, last_a;
  logic         ready_b, so_b, busy_b, last_b;

  typedef struct {
    logic bit_a;
    logic bit_b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  always #5 c = ~c;

  piso_serializer #(.WIDTH(W), .INIT_VAL(1'b0), .MSB_FIRST(1'b1)) dut_a (
    .C(c), .CLR(clr), .DIN(din), .LOAD(load),
    .READY(ready_a), .SO(so_a), .BUSY(busy_a), .LAST(last_a)
  );

  piso_serializer #(.WIDTH(W), .INIT_VAL(1'b1), .MSB_FIRST(1'b0)) dut_b (
    .C(c), .CLR(clr), .DIN(din), .LOAD(load),
    .READY(ready_b), .SO(so_b), .BUSY(busy_b), .LAST(last_b)
  );

  task automatic chk(input string name, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: a word is accepted only when no undelivered bits remain;
  // it contributes W bits in transmission order. CLR drops everything pending.
  task automatic apply(input logic clr_i, input logic load_i, input logic [W-1:0] din_i);
    clr  = clr_i;
    load = load_i;
    din  = din_i;
    if (clr_i) begin
      exp_q.delete();
    end else if (load_i && exp_q.size() == 0) begin
      for (int i = 0; i < W; i++)
        exp_q.push_back('{din_i[W-1-i], din_i[i], (i == W - 1)});
    end
  endtask

  task automatic drive(input logic clr_i, input logic load_i, input logic [W-1:0] din_i);
    @(negedge c);
    apply(clr_i, load_i, din_i);
  endtask

  task automatic load_when_ready(input logic [W-1:0] d);
    int n = 0;
    @(negedge c);
    while (exp_q.size() != 0 && n < 32) begin
      apply(1'b0, 1'b0, 8'h00);
      @(negedge c);
      n++;
    end
    chk("ready_wait", logic'(n < 32), 1'b1);
    apply(1'b0, 1'b1, d);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 32) begin
      drive(1'b0, 1'b0, 8'h00);
      n++;
    end
    chk("drain", logic'(exp_q.size() == 0), 1'b1);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
  endtask

  // Monitor: a busy DUT must deliver the next queued bit; an idle one must sit at its idle level.
  initial begin
    exp_t e;
    forever begin
      @(posedge c);
      #1;
      if (mon_en) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("busy_a", busy_a, 1'b1);
          chk("busy_b", busy_b, 1'b1);
          chk("so_a", so_a, e.bit_a);
          chk("so_b", so_b, e.bit_b);
          chk("last_a", last_a, e.last);
          chk("last_b", last_b, e.last);
          chk("ready_a", ready_a, e.last);
          chk("ready_b", ready_b, e.last);
        end else begin
          chk("idle_busy_a", busy_a, 1'b0);
          chk("idle_busy_b", busy_b, 1'b0);
          chk("idle_so_a", so_a, 1'b0);
          chk("idle_so_b", so_b, 1'b1);
          chk("idle_last_a", last_a, 1'b0);
          chk("idle_last_b", last_b, 1'b0);
          chk("idle_ready_a", ready_a, 1'b1);
          chk("idle_ready_b", ready_b, 1'b1);
        end
      end
    end
  end

  initial begin
    clr  = 1'b1;
    load = 1'b0;
    din  = 8'h00;
    repeat (2) @(posedge c);
    drive(1'b1, 1'b0, 8'h00);
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 8'h00);

    // single word
    drive(1'b0, 1'b1, 8'hA5);
    drain();

    // back-to-back words reloaded in the LAST cycle
    drive(1'b0, 1'b1, 8'hA5);
    load_when_ready(8'h3C);
    drain();

    // clear one cycle after the third bit, then an immediate reload
    drive(1'b0, 1'b1, 8'hFF);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h81);
    drain();

    // simultaneous clear and load
    drive(1'b1, 1'b1, 8'hFF);
    drain();

    // load while not ready is ignored
    drive(1'b0, 1'b1, 8'hF0);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    drain();

    // single set bit: LSB-first instance sends it first
    drive(1'b0, 1'b1, 8'h01);
    drain();

    // random traffic
    repeat (400)
      drive(logic'($urandom_range(0, 19) == 0), logic'($urandom_range(0, 2) != 0), 8'($urandom));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
